// File: rtl/sap_1_controller_sequencer_if.sv
// Handshake bundle between the SAP-1 instruction decoder and the controller-sequencer.
// The decoder drives the opcode strobes; the controller drives the ring state, control word and halt flag.
interface sap_1_controller_sequencer_if;
    logic        LDA;
    logic        ADD;
    logic        SUB;
    logic        OUT;
    logic        HLT;
    logic [5:0]  T;
    logic [11:0] CON;
    logic        HALT;

    modport master (
        output LDA,
        output ADD,
        output SUB,
        output OUT,
        output HLT,
        input  T,
        input  CON,
        input  HALT
    );

    modport slave (
        input  LDA,
        input  ADD,
        input  SUB,
        input  OUT,
        input  HLT,
        output T,
        output CON,
        output HALT
    );
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter with a combinational
// control-word decode; HLT in T4 freezes the machine until CLR.
module sap_1_controller_sequencer (
    input  logic                          CLK,
    input  logic                          CLR,
    sap_1_controller_sequencer_if.slave   ctl
);

    // State encoding doubles as the one-hot T output; the halted state is all-zero.
    typedef enum logic [5:0] {
        ST_HALT = 6'b000000,
        ST_T1   = 6'b000001,
        ST_T2   = 6'b000010,
        ST_T3   = 6'b000100,
        ST_T4   = 6'b001000,
        ST_T5   = 6'b010000,
        ST_T6   = 6'b100000
    } state_e;

    localparam logic [11:0] CW_CP = 12'h800;
    localparam logic [11:0] CW_EP = 12'h400;
    localparam logic [11:0] CW_LM = 12'h200;
    localparam logic [11:0] CW_CE = 12'h100;
    localparam logic [11:0] CW_LI = 12'h080;
    localparam logic [11:0] CW_EI = 12'h040;
    localparam logic [11:0] CW_LA = 12'h020;
    localparam logic [11:0] CW_EA = 12'h010;
    localparam logic [11:0] CW_SU = 12'h008;
    localparam logic [11:0] CW_EU = 12'h004;
    localparam logic [11:0] CW_LB = 12'h002;
    localparam logic [11:0] CW_LO = 12'h001;
    localparam logic [11:0] CW_NOP = 12'h000;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1000;

    state_e      state_q;
    state_e      state_d;
    logic        halt_q;
    logic        halt_d;
    logic [11:0] con_s;
    logic [3:0]  op_s;
    logic        legal_s;

    function automatic logic exactly_one(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    assign op_s    = {ctl.OUT, ctl.SUB, ctl.ADD, ctl.LDA};
    assign legal_s = exactly_one(op_s) && !ctl.HLT;

    // State and halt-flag registers; CLR forces T1 immediately.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_T1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Ring advance and control-word decode.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        con_s   = CW_NOP;
        case (state_q)
            ST_T1: begin
                state_d = ST_T2;
                con_s   = CW_EP | CW_LM;
            end
            ST_T2: begin
                state_d = ST_T3;
                con_s   = CW_CP;
            end
            ST_T3: begin
                state_d = ST_T4;
                con_s   = CW_CE | CW_LI;
            end
            ST_T4: begin
                if (ctl.HLT) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    con_s   = CW_NOP;
                end else begin
                    state_d = ST_T5;
                    if (legal_s) begin
                        case (op_s)
                            OP_LDA:  con_s = CW_EI | CW_LM;
                            OP_ADD:  con_s = CW_EI | CW_LM;
                            OP_SUB:  con_s = CW_EI | CW_LM;
                            OP_OUT:  con_s = CW_EA | CW_LO;
                            default: con_s = CW_NOP;
                        endcase
                    end else begin
                        con_s = CW_NOP;
                    end
                end
            end
            ST_T5: begin
                state_d = ST_T6;
                if (legal_s) begin
                    case (op_s)
                        OP_LDA:  con_s = CW_CE | CW_LA;
                        OP_ADD:  con_s = CW_CE | CW_LB;
                        OP_SUB:  con_s = CW_CE | CW_LB;
                        OP_OUT:  con_s = CW_NOP;
                        default: con_s = CW_NOP;
                    endcase
                end else begin
                    con_s = CW_NOP;
                end
            end
            ST_T6: begin
                state_d = ST_T1;
                if (legal_s) begin
                    case (op_s)
                        OP_LDA:  con_s = CW_NOP;
                        OP_ADD:  con_s = CW_EU | CW_LA;
                        OP_SUB:  con_s = CW_SU | CW_EU | CW_LA;
                        OP_OUT:  con_s = CW_NOP;
                        default: con_s = CW_NOP;
                    endcase
                end else begin
                    con_s = CW_NOP;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
                halt_d  = 1'b1;
                con_s   = CW_NOP;
            end
            default: begin
                // Unreachable encodings recover to the start of a fetch.
                state_d = ST_T1;
                halt_d  = 1'b0;
                con_s   = CW_NOP;
            end
        endcase
    end

    assign ctl.T    = state_q;
    assign ctl.HALT = halt_q;
    assign ctl.CON  = con_s;

endmodule

// File: doc/sap_1_controller_sequencer.md
Name: sap_1_controller_sequencer

Overview:
- Control unit for the SAP-1 computer.
- Consumes the one-hot opcode strobes from the instruction decoder: LDA, ADD, SUB, OUT, HLT.
- Runs a 6-state ring counter (T1..T6) and drives the 12-bit control word that steers the PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
- Halts the machine on HLT.

Parameters:
- None. Ring length is fixed at 6 and control-word width is fixed at 12.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-high reset.
- LDA  input  1  decoded opcode 0000.
- ADD  input  1  decoded opcode 0001.
- SUB  input  1  decoded opcode 0010.
- OUT  input  1  decoded opcode 1110.
- HLT  input  1  decoded opcode 1111.
- T    output 6  ring state, one-hot; T[0]=T1 .. T[5]=T6; all-zero when halted.
- CON  output 12 control word, all bits active-high:
  - [11]=Cp (PC increment), [10]=Ep (PC to bus), [9]=Lm (load MAR), [8]=Ce (RAM to bus)
  - [7]=Li (load IR), [6]=Ei (IR low nibble to bus), [5]=La (load A), [4]=Ea (A to bus)
  - [3]=Su (subtract), [2]=Eu (ALU to bus), [1]=Lb (load B), [0]=Lo (load output register)
- HALT output 1  1 while halted.

Behaviour:
- Reset: one clock, CLK. CLR is asynchronous and active-high; while CLR=1: T=6'b000001 (T1), HALT=0.
- CON is a combinational decode of registered T plus the opcode strobes, so in reset CON=12'h600 (Ep|Lm).
- Ring: T1->T2->...->T6->T1, advancing one state per rising edge. No other state transitions except halt and CLR.
- Opcode inputs are meaningful only in T4..T6, after IR is loaded at the end of T3. They are ignored in T1..T3.
- Fetch cycle, identical for all instructions:
  - T1: Ep, Lm (12'h600)
  - T2: Cp (12'h800)
  - T3: Ce, Li (12'h180)
- Execute cycle:
  - LDA: T4 Ei, Lm (12'h240); T5 Ce, La (12'h120); T6 none (12'h000).
  - ADD: T4 Ei, Lm (12'h240); T5 Ce, Lb (12'h102); T6 Eu, La (12'h024).
  - SUB: T4 Ei, Lm (12'h240); T5 Ce, Lb (12'h102); T6 Su, Eu, La (12'h02C).
  - OUT: T4 Ea, Lo (12'h011); T5 none; T6 none.
- HLT:
  - Sampled in T4 only. When T4 and HLT=1, CON=12'h000 in that cycle, regardless of other strobes.
  - At the next rising edge: T=6'b000000 and HALT=1.
  - While halted: CON=12'h000, the state is frozen and all inputs are ignored. Only CLR exits the halted state.
- Illegal strobes: if zero strobes, or more than one, are asserted in T4..T6 without HLT, that cycle is a NOP (CON=12'h000). The ring still advances.
- Bus exclusivity: at most one of Ep, Ce, Ei, Ea, Eu is high in any cycle.
- CLR mid-instruction: immediate return to T1/HALT=0 with no completion of the current instruction. Release of CLR takes effect at the next rising edge.
- Total instruction latency is 6 clocks. A program of N non-HLT instructions followed by HLT reaches HALT=1 at 6N+4 edges after CLR release.

Test Plan:
- Reset: hold CLR=1 over 3 edges -> T=000001, CON=12'h600, HALT=0. Assert CLR asynchronously mid-cycle -> T=000001 without waiting for an edge.
- LDA: LDA=1 for 6 clocks from T1 -> CON sequence 600, 800, 180, 240, 120, 000. T returns to 000001 on the 7th cycle.
- ADD then SUB: back-to-back -> T4..T6 give 240, 102, 024, then 240, 102, 02C. Fetch is 600, 800, 180 each time.
- OUT: in T4 -> CON=12'h011; T5 and T6 give 000.
- HLT after LDA: HALT=1 exactly 10 edges after CLR release. T=000000 and CON=000 for 20 more clocks with random strobes. Pulse CLR -> T=000001, HALT=0.
- Illegal: ADD=SUB=1 in T4..T6 -> CON=000 in all three cycles and the ring wraps to T1. All-zero strobes -> same result. A strobe in T1..T3 does not change the fetch control words.
